// File: rtl/serial_frame_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_frame_pkg                                                           |
// | Frame constants and sync-state type shared by the serial frame tx and rx.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package serial_frame_pkg;

  localparam int   FRAME_BITS = 10;
  localparam int   DATA_BITS  = 8;
  localparam logic MARKER_BIT = 1'b1;
  localparam logic END_BIT    = 1'b0;

  typedef enum logic [0:0] {
    HUNT   = 1'b0,
    LOCKED = 1'b1
  } sync_state_t;

  // Frame as held in the receive shift register: {end, d7..d0, marker}.
  function automatic logic frame_is_good(input logic [FRAME_BITS-1:0] f);
    return (f[0] == MARKER_BIT) && (f[FRAME_BITS-1] == END_BIT);
  endfunction

endpackage
`default_nettype wire

// File: rtl/serial_seq_checker.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_seq_checker                                                         |
// | Flags a break in an incrementing payload stream (mod 256) while locked.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module serial_seq_checker
  import serial_frame_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 locked,
  input  logic                 rx_valid,
  input  logic [DATA_BITS-1:0] rx_data,
  output logic                 seq_err
);

  logic                 r_have_exp;
  logic [DATA_BITS-1:0] r_prev;
  logic                 r_seq_err;

  // Inputs are the receiver's next-cycle strobes, so seq_err lines up with rx_valid.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_have_exp <= 1'b0;
      r_prev     <= '0;
      r_seq_err  <= 1'b0;
    end else if (!locked) begin
      r_have_exp <= 1'b0;
      r_seq_err  <= 1'b0;
    end else if (rx_valid) begin
      r_seq_err  <= r_have_exp && (rx_data != r_prev + 8'd1);
      r_prev     <= rx_data;
      r_have_exp <= 1'b1;
    end else begin
      r_seq_err  <= 1'b0;
    end
  end

  assign seq_err = r_seq_err;

endmodule
`default_nettype wire

// File: rtl/serial_frame_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | serial_frame_rx                                                            |
// | Hunts for 10-bit frame alignment, locks, and delivers one byte per frame.  |
// | Optional macro: SERIAL_FRAME_RX_SEQ_CHECK_EN adds an incrementing checker. |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module serial_frame_rx
  import serial_frame_pkg::*;
#(
  parameter int LOCK_FRAMES = 3,
  parameter int LOSS_FRAMES = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 locked,
  output logic                 frame_err,
  output logic                 seq_err
);

  localparam logic [0:0] c_ST_HUNT   = 1'(HUNT);
  localparam logic [0:0] c_ST_LOCKED = 1'(LOCKED);
  localparam logic [3:0] c_LAST_BIT  = 4'(FRAME_BITS - 1);
  localparam logic [3:0] c_LOCK_CNT  = 4'(LOCK_FRAMES);
  localparam logic [3:0] c_LOSS_CNT  = 4'(LOSS_FRAMES);

  logic [FRAME_BITS-1:0] r_sr;
  logic [3:0]            r_bit_cnt;
  logic                  r_frame_done;
  logic [0:0]            r_state;
  logic [3:0]            r_good_cnt;
  logic [3:0]            r_bad_cnt;
  logic [DATA_BITS-1:0]  r_rx_data;
  logic                  r_rx_valid;
  logic                  r_frame_err;

  logic [0:0]            w_state_nxt;
  logic [3:0]            w_good_nxt;
  logic [3:0]            w_bad_nxt;
  logic [3:0]            w_bit_cnt_nxt;
  logic [DATA_BITS-1:0]  w_data_nxt;
  logic                  w_valid_nxt;
  logic                  w_err_nxt;
  logic                  w_slip;
  logic                  w_good;

  assign w_good = frame_is_good(r_sr);

  // r_frame_done marks the cycle after the end bit landed, when r_sr holds a whole frame.
  always_comb begin
    w_state_nxt = r_state;
    w_good_nxt  = r_good_cnt;
    w_bad_nxt   = r_bad_cnt;
    w_data_nxt  = r_rx_data;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    w_slip      = 1'b0;
    if (r_frame_done) begin
      case (r_state)
        c_ST_HUNT: begin
          if (w_good) begin
            w_good_nxt = r_good_cnt + 4'd1;
            if (r_good_cnt + 4'd1 == c_LOCK_CNT) begin
              w_state_nxt = c_ST_LOCKED;
              w_bad_nxt   = '0;
              w_valid_nxt = 1'b1;
              w_data_nxt  = r_sr[DATA_BITS:1];
            end
          end else begin
            w_good_nxt = '0;
            w_slip     = 1'b1;
          end
        end
        default: begin
          if (w_good) begin
            w_bad_nxt   = '0;
            w_valid_nxt = 1'b1;
            w_data_nxt  = r_sr[DATA_BITS:1];
          end else begin
            w_err_nxt = 1'b1;
            w_bad_nxt = r_bad_cnt + 4'd1;
            if (r_bad_cnt + 4'd1 == c_LOSS_CNT) begin
              w_state_nxt = c_ST_HUNT;
              w_good_nxt  = '0;
              w_slip      = 1'b1;
            end
          end
        end
      endcase
    end
  end

  // A slip keeps bit_cnt at 0 one extra cycle, pushing the window one bit later.
  always_comb begin
    w_bit_cnt_nxt = r_bit_cnt + 4'd1;
    if (w_slip || (r_bit_cnt == c_LAST_BIT)) begin
      w_bit_cnt_nxt = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_sr         <= '0;
      r_bit_cnt    <= '0;
      r_frame_done <= 1'b0;
      r_state      <= c_ST_HUNT;
      r_good_cnt   <= '0;
      r_bad_cnt    <= '0;
      r_rx_data    <= '0;
      r_rx_valid   <= 1'b0;
      r_frame_err  <= 1'b0;
    end else begin
      r_sr         <= {rx, r_sr[FRAME_BITS-1:1]};
      r_bit_cnt    <= w_bit_cnt_nxt;
      r_frame_done <= (r_bit_cnt == c_LAST_BIT);
      r_state      <= w_state_nxt;
      r_good_cnt   <= w_good_nxt;
      r_bad_cnt    <= w_bad_nxt;
      r_rx_data    <= w_data_nxt;
      r_rx_valid   <= w_valid_nxt;
      r_frame_err  <= w_err_nxt;
    end
  end

  assign rx_data   = r_rx_data;
  assign rx_valid  = r_rx_valid;
  assign frame_err = r_frame_err;
  assign locked    = (r_state == c_ST_LOCKED);

`ifdef SERIAL_FRAME_RX_SEQ_CHECK_EN
  logic w_locked_nxt;
  assign w_locked_nxt = (w_state_nxt == c_ST_LOCKED);

  serial_seq_checker u_seq_checker (
    .clk      (clk),
    .reset_n  (reset_n),
    .locked   (w_locked_nxt),
    .rx_valid (w_valid_nxt),
    .rx_data  (w_data_nxt),
    .seq_err  (seq_err)
  );
`else
  assign seq_err = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_serial_frame_rx                                                         |
// | Self-checking bench: frame-timeline reference model, table and sequences.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_serial_frame_rx;

  localparam int LOCK_FRAMES = 3;
  localparam int LOSS_FRAMES = 2;
`ifdef SERIAL_FRAME_RX_SEQ_CHECK_EN
  localparam bit SEQ_ON = 1'b1;
`else
  localparam bit SEQ_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       rx = 1'b0;
  logic [7:0] rx_data;
  logic       rx_valid, locked, frame_err, seq_err;

  int checks = 0;
  int errors = 0;

  serial_frame_rx #(.LOCK_FRAMES(LOCK_FRAMES), .LOSS_FRAMES(LOSS_FRAMES)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .locked    (locked),
    .frame_err (frame_err),
    .seq_err   (seq_err)
  );

  always #5 clk = ~clk;

  // Reference model: bit history indexed by edge number since reset release,
  // and the edge number at which the current frame window is judged.
  bit         hist [0:8191];
  int         t, m_next_eval, m_good, m_bad;
  bit         m_locked, m_have;
  logic [7:0] m_prev, e_data;
  bit         e_valid, e_ferr, e_serr;

  int         n_valid, n_ferr, n_serr, n_locked, first_valid_t, last_valid_t;
  logic [7:0] first_valid_data;
  bit         chk_spacing, saw_wrap;
  bit         cap_valid, cap_ferr, cap_serr, cap_locked;
  logic [7:0] cap_data;

  typedef struct {
    logic [7:0] data;
    bit bad_end, bad_mark;
    bit exp_valid, exp_ferr, exp_serr, exp_locked;
  } vec_t;
  vec_t tbl [5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0d)", name, act, exp, t);
    end
  endtask

  task automatic model_reset();
    t = 0; m_next_eval = 11; m_good = 0; m_bad = 0;
    m_locked = 0; m_have = 0; m_prev = 8'h00;
    e_data = 8'h00; e_valid = 0; e_ferr = 0; e_serr = 0;
    n_valid = 0; n_ferr = 0; n_serr = 0; n_locked = 0;
    first_valid_t = 0; last_valid_t = 0; first_valid_data = 8'h00; saw_wrap = 0;
  endtask

  task automatic model_deliver(input logic [7:0] d);
    e_valid = 1; e_data = d;
    if (SEQ_ON) begin
      if (m_have && d != 8'(m_prev + 8'd1)) e_serr = 1;
      m_prev = d; m_have = 1;
    end
  endtask

  task automatic model_edge(input bit b);
    bit good, slip;
    logic [7:0] pay;
    t++;
    if (t < 8192) hist[t] = b;
    e_valid = 0; e_ferr = 0; e_serr = 0;
    if (t == m_next_eval && t >= 11) begin
      for (int i = 0; i < 8; i++) pay[i] = hist[t-9+i];
      good = hist[t-10] && !hist[t-1];
      slip = 0;
      if (!m_locked) begin
        if (good) begin
          m_good++;
          if (m_good == LOCK_FRAMES) begin
            m_locked = 1; m_bad = 0; m_have = 0;
            model_deliver(pay);
          end
        end else begin
          m_good = 0; slip = 1;
        end
      end else if (good) begin
        m_bad = 0;
        model_deliver(pay);
      end else begin
        e_ferr = 1; m_bad++;
        if (m_bad == LOSS_FRAMES) begin
          m_locked = 0; m_good = 0; m_have = 0; slip = 1;
        end
      end
      m_next_eval = t + (slip ? 11 : 10);
    end
  endtask

  task automatic tick(input bit b);
    rx = b;
    @(posedge clk);
    model_edge(b);
    #1;
    check("cycle {lock,valid,ferr,serr,data}", {locked, rx_valid, frame_err, seq_err, rx_data},
          {m_locked, e_valid, e_ferr, e_serr, e_data});
    if (rx_valid === 1'b1) begin
      n_valid++;
      if (first_valid_t == 0) begin first_valid_t = t; first_valid_data = rx_data; end
      if (chk_spacing && last_valid_t > 0) check("valid_spacing", t - last_valid_t, 10);
      last_valid_t = t;
      if (rx_data === 8'h00) saw_wrap = 1;
    end
    if (frame_err === 1'b1) n_ferr++;
    if (seq_err === 1'b1) n_serr++;
    if (locked === 1'b1) n_locked++;
  endtask

  task automatic send_frame(input logic [7:0] d, input bit bad_end, input bit bad_mark);
    tick(!bad_mark);
    cap_valid = rx_valid; cap_ferr = frame_err; cap_serr = seq_err;
    cap_locked = locked; cap_data = rx_data;
    for (int i = 0; i < 8; i++) tick(d[i]);
    tick(bad_end);
  endtask

  task automatic do_reset();
    #2 reset_n = 1'b0;
    #1 check("reset_outputs", {locked, rx_valid, frame_err, seq_err, rx_data}, 12'h000);
    @(posedge clk);
    @(posedge clk);
    #1 reset_n = 1'b1;
    model_reset();
  endtask

  task automatic check_tbl(input int i);
    check("tbl_valid", cap_valid, tbl[i].exp_valid);
    check("tbl_frame_err", cap_ferr, tbl[i].exp_ferr);
    check("tbl_seq_err", cap_serr, tbl[i].exp_serr);
    check("tbl_locked", cap_locked, tbl[i].exp_locked);
    if (tbl[i].exp_valid) check("tbl_data", cap_data, tbl[i].data);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0] = '{8'h08, 0, 0, 1, 0, 0,      1};
    tbl[1] = '{8'h09, 1, 0, 0, 1, 0,      1};
    tbl[2] = '{8'h0A, 0, 0, 1, 0, SEQ_ON, 1};
    tbl[3] = '{8'h0B, 0, 1, 0, 1, 0,      1};
    tbl[4] = '{8'h0C, 1, 0, 0, 1, 0,      0};

    // Aligned counting stream from the first cycle after reset.
    do_reset();
    chk_spacing = 1;
    for (int k = 0; k < 8; k++) send_frame(8'(k), 0, 0);
    chk_spacing = 0;
    check("lock_cycle", first_valid_t, 31);
    check("lock_first_data", first_valid_data, 8'h02);
    check("aligned_seq_err", n_serr, 0);

    // Single bad frame, then two consecutive bad frames while locked.
    for (int i = 0; i < 5; i++) begin
      send_frame(tbl[i].data, tbl[i].bad_end, tbl[i].bad_mark);
      if (i > 0) check_tbl(i - 1);
    end
    send_frame(8'h0D, 0, 0);
    check_tbl(4);
    for (int k = 0; k < 30 && locked !== 1'b1; k++) send_frame(8'(8'h0E + k), 0, 0);
    check("relock_after_loss", locked, 1'b1);

    // Misaligned start: 4-bit offset, stream wraps 0xFF -> 0x00 after lock.
    do_reset();
    for (int i = 0; i < 4; i++) tick(0);
    for (int k = 0; k < 40; k++) send_frame(8'(8'hF0 + k), 0, 0);
    check("mis_locked", locked, 1'b1);
    check("mis_slipped", first_valid_t > 31, 1);
    check("mis_wrap_seen", saw_wrap, 1);
    check("mis_seq_err", n_serr, 0);

    // Stuck-at-0 input.
    do_reset();
    for (int i = 0; i < 200; i++) tick(0);
    check("stuck_valid", n_valid, 0);
    check("stuck_frame_err", n_ferr, 0);
    check("stuck_locked", n_locked, 0);

    // Reset mid-frame while locked, then a skipped payload.
    do_reset();
    for (int k = 0; k < 6; k++) send_frame(8'(k), 0, 0);
    for (int i = 0; i < 5; i++) tick(1);
    check("pre_reset_locked", locked, 1'b1);
    do_reset();
    for (int k = 0; k < 10; k++) send_frame(8'(8'h20 + k + (k >= 5 ? 1 : 0)), 0, 0);
    check("rst_relock_cycle", first_valid_t, 31);
    check("skip_seq_err_count", n_serr, SEQ_ON ? 1 : 0);

    // Randomized phase, payloads and corruptions against the model.
    for (int r = 0; r < 4; r++) begin
      int off;
      do_reset();
      off = $urandom_range(0, 9);
      for (int i = 0; i < off; i++) tick(1'($urandom_range(0, 1)));
      for (int k = 0; k < 60; k++) begin
        int p;
        p = $urandom_range(0, 99);
        send_frame(8'($urandom), p < 6, p >= 6 && p < 10);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_frame_rx.md
# serial_frame_rx

Receiver and frame synchronizer for the continuous one-bit-per-clock serial stream of 10-bit frames produced by the team's serial frame transmitter. The frame on the wire, in time order, is: a marker bit `1`, data bits d0..d7 (LSB first), then an end bit `0`. Frames arrive back to back with no idle gap. The block hunts for frame alignment, declares lock, and then delivers one 8-bit byte per good frame. It sits at the far end of the serial link, on the same clock as the transmitter.

## Interface
Parameters:
- LOCK_FRAMES, default 3: number of consecutive good frames required to declare lock (range 1..15).
- LOSS_FRAMES, default 2: number of consecutive bad frames while locked that force a return to hunt (range 1..15).

Ports:
- clk  in  1  system clock; one serial bit per rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- rx  in  1  serial input; sampled on every rising edge.
- rx_data  out  8  last good payload byte; held between frames.
- rx_valid  out  1  one-cycle pulse; rx_data is new and valid.
- locked  out  1  high while the frame synchronizer is in LOCKED.
- frame_err  out  1  one-cycle pulse on a bad frame while locked.
- seq_err  out  1  one-cycle pulse on a payload sequence break; constant 0 when the macro is off.

## Operation
- **Shift register.** sr[9:0] shifts right on every clk with rx entering sr[9]. After 10 samples, sr equals {end, d7..d0, marker}.
- **Good frame.** A frame is good when sr[0]==1 and sr[9]==0. The payload is sr[8:1].
- **Boundary counter.** bit_cnt (4 bits) counts 0..9. The frame is evaluated when bit_cnt==9, and bit_cnt then wraps to 0.
- **Slip.** A slip holds bit_cnt at 0 for one extra cycle. That boundary interval is 11 cycles, which moves the frame window one bit later. sr keeps shifting during the slip.
- **FSM states:** HUNT and LOCKED. good_cnt and bad_cnt are 4-bit counters.
- **HUNT, good frame:** good_cnt++. When good_cnt reaches LOCK_FRAMES, go to LOCKED, clear bad_cnt, and emit that frame on rx_data with rx_valid.
- **HUNT, bad frame:** clear good_cnt and slip. There is no frame_err in HUNT.
- **LOCKED, good frame:** clear bad_cnt and pulse rx_valid with the new rx_data.
- **LOCKED, bad frame:** pulse frame_err, bad_cnt++, no rx_valid, no slip. When bad_cnt reaches LOSS_FRAMES, go to HUNT, clear good_cnt, and slip.
- **Reset.** All outputs and internal state reset to 0: rx_data=0, rx_valid=0, locked=0, frame_err=0, seq_err=0, state HUNT, sr=0, bit_cnt=0. Reset asserted mid-frame discards the partial frame. After release, the hunt restarts with bit_cnt=0.
- **All-zero stream.** A stream stuck at 0 never satisfies the marker, so the block stays in HUNT and slips every 11 cycles.

## Timing
- rx_valid, rx_data, frame_err and seq_err are registered and assert on the clk edge after the edge that sampled the frame's end bit. Latency is 1 cycle.
- locked rises on the same edge as the rx_valid of the lock-completing frame. locked falls on the same edge as the frame_err that exhausts LOSS_FRAMES.
- Locked throughput is 1 byte per 10 cycles. rx_valid pulses are exactly 10 cycles apart.
- Worst-case acquisition from an arbitrary phase is 9 slips plus LOCK_FRAMES good frames. This bound assumes no data pattern mimics the delimiters. Payload patterns that mimic the delimiters can cause false lock; this is accepted, and detection relies on LOSS_FRAMES.

## Configuration
- **SERIAL_FRAME_RX_SEQ_CHECK_EN defined:** an incrementing-payload checker is built in.
  - The first rx_valid after entering LOCKED only loads the expected value.
  - Each later rx_valid compares rx_data against prev+1 mod 256, so 255→0 is legal. A mismatch pulses seq_err together with rx_valid, and the expectation resyncs to the received byte.
  - Leaving LOCKED clears the checker.
- **Macro not defined:** the checker is absent and seq_err is tied to 0.

## Structure
- Package serial_frame_pkg holds FRAME_BITS=10, DATA_BITS=8, MARKER_BIT=1'b1, END_BIT=1'b0, and the enum typedef sync_state_t {HUNT, LOCKED}. The transmitter shares the same constants.
- One sub-module, serial_seq_checker, instantiated only under SERIAL_FRAME_RX_SEQ_CHECK_EN. Inputs: clk, reset_n, locked, rx_valid, rx_data. Output: seq_err.

## Test plan
- **Aligned counting stream.** Bytes 0x00,0x01,... sent from the first cycle after reset → locked rises with rx_valid at cycle 31 carrying 0x02. After that, one rx_valid every 10 cycles; seq_err stays 0.
- **Misaligned start.** Stream offset by 4 bits → at least one slip, then lock. Every received byte matches the sent sequence, and the 0xFF→0x00 wrap raises no seq_err.
- **Single corrupted end bit while locked.** → one frame_err, no rx_valid for that frame, locked stays 1, and the next frame is delivered normally. A seq_err pulse on the next frame is expected only when the macro is on.
- **Two consecutive corrupted frames.** (LOSS_FRAMES=2) → two frame_err pulses, locked falls on the second, the block re-hunts and relocks after 3 good frames.
- **Stuck-at-0 input.** → locked stays 0, rx_valid never asserts, frame_err stays 0.
- **reset_n pulsed mid-frame while locked.** → all outputs 0 immediately, then a fresh hunt. Repeated skipped payload (macro on) → seq_err pulses once, then resyncs.
